dm_store_buffer: RTL and testbench

Word-granular store buffer between the MEM-stage store path and the data memory. The data memory has one shared combinational-read address port and whole-word writes only. Stores carrying byte enables are queued here and drained into the memory one per cycle as read-modify-write words. Loads take priority on the shared address port and see buffered bytes forwarded over the memory word.

---
 rtl/dm_store_buffer_if.sv | 32 +++
 rtl/dm_store_buffer.sv | 121 ++++++++++++
 tb/tb_dm_store_buffer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_store_buffer_if.sv
// Store, load and data-memory port bundle for the word-granular store buffer.
// The slave side is the buffer; the master side is the pipeline plus memory.
interface dm_store_buffer_if #(
    parameter int PW = 2
);
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          ld_req;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_rd;
    logic [31:0]   dm_wd;
    logic          dm_we;
    logic [31:0]   dm_pc;
    logic [PW:0]   count;
    logic          empty;

    modport slave (
        input  st_valid, st_addr, st_wdata, st_be, st_pc, ld_req, ld_addr, dm_rd,
        output st_ready, ld_data, dm_addr, dm_wd, dm_we, dm_pc, count, empty
    );

    modport master (
        output st_valid, st_addr, st_wdata, st_be, st_pc, ld_req, ld_addr, dm_rd,
        input  st_ready, ld_data, dm_addr, dm_wd, dm_we, dm_pc, count, empty
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Circular store buffer draining byte-enabled stores into a whole-word memory
// as read-modify-write words; loads own the shared port and see forwarded bytes.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    dm_store_buffer_if.slave sb
);
    logic [29:0]   r_waddr [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic [3:0]    r_be    [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic [PW-1:0] w_young;
    logic [PW-1:0] w_idx;
    logic          w_nonempty;
    logic          w_has_room;
    logic          w_drain;
    logic          w_coalesce;
    logic          w_alloc;
    logic          w_hit;
    logic [31:0]   w_fwd;
    logic          w_unused;

    assign w_young  = r_tail - PW'(1);
    assign w_unused = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    // Arbitration between load and drain, and store acceptance decisions
    always_comb begin
        w_nonempty = (r_count != (PW+1)'(0));
        w_has_room = (r_count < (PW+1)'(DEPTH));
        w_drain    = ~sb.ld_req & w_nonempty;
        // The youngest entry may not be merged while it is also the head being written out.
        w_coalesce = sb.st_valid & w_nonempty
                   & (sb.st_addr[31:2] == r_waddr[w_young])
                   & ~(w_drain & (w_young == r_head));
        w_alloc    = sb.st_valid & (sb.st_be != 4'b0000) & ~w_coalesce & w_has_room;
    end

    // Memory port: load address, head-entry RMW write, or idle zeros
    always_comb begin
        sb.dm_addr = 32'h0000_0000;
        sb.dm_wd   = 32'h0000_0000;
        sb.dm_we   = 1'b0;
        sb.dm_pc   = 32'h0000_0000;
        if (sb.ld_req) begin
            sb.dm_addr = {sb.ld_addr[31:2], 2'b00};
        end else if (w_nonempty) begin
            sb.dm_addr = {r_waddr[r_head], 2'b00};
            sb.dm_we   = 1'b1;
            sb.dm_pc   = r_pc[r_head];
            for (int b = 0; b < 4; b++) begin
                sb.dm_wd[8*b +: 8] = r_be[r_head][b] ? r_data[r_head][8*b +: 8]
                                                     : sb.dm_rd[8*b +: 8];
            end
        end else begin
            sb.dm_we = 1'b0;
        end
    end

    // Load forwarding: walk oldest to youngest so the youngest matching lane wins
    always_comb begin
        w_fwd = sb.dm_rd;
        w_idx = r_head;
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            w_hit = ((PW+1)'(i) < r_count) & (r_waddr[w_idx] == sb.ld_addr[31:2]);
            for (int b = 0; b < 4; b++) begin
                w_fwd[8*b +: 8] = (w_hit & r_be[w_idx][b]) ? r_data[w_idx][8*b +: 8]
                                                           : w_fwd[8*b +: 8];
            end
        end
    end

    assign sb.ld_data  = w_fwd;
    assign sb.st_ready = w_has_room | w_coalesce;
    assign sb.count    = r_count;
    assign sb.empty    = (r_count == (PW+1)'(0));

    // Entry storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= PW'(0);
            r_tail  <= PW'(0);
            r_count <= (PW+1)'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= 30'h0;
                r_data[i]  <= 32'h0000_0000;
                r_be[i]    <= 4'b0000;
                r_pc[i]    <= 32'h0000_0000;
            end
        end else begin
            if (w_coalesce) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb.st_be[b]) begin
                        r_data[w_young][8*b +: 8] <= sb.st_wdata[8*b +: 8];
                    end
                end
                r_be[w_young] <= r_be[w_young] | sb.st_be;
                r_pc[w_young] <= sb.st_pc;
            end
            if (w_alloc) begin
                r_waddr[r_tail] <= sb.st_addr[31:2];
                r_data[r_tail]  <= sb.st_wdata;
                r_be[r_tail]    <= sb.st_be;
                r_pc[r_tail]    <= sb.st_pc;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + (PW+1)'(w_alloc) - (PW+1)'(w_drain);
        end
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Randomized scoreboard bench for dm_store_buffer: a queue-and-array reference
// model predicts every cycle's outputs; a monitor compares on the falling edge.
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clk = ~clk;

    dm_store_buffer_if #(.PW(PW)) bus ();
    dm_store_buffer #(.DEPTH(DEPTH), .PW(PW)) dut (.clk(clk), .reset(reset), .sb(bus.slave));

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Bench-side data memory: combinational read, whole-word write
    logic [31:0] mem [64];
    assign bus.dm_rd = mem[bus.dm_addr[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else if (bus.dm_we) begin
            mem[bus.dm_addr[7:2]] <= bus.dm_wd;
        end
    end

    typedef struct { logic [29:0] wa; logic [31:0] d; logic [3:0] be; logic [31:0] pc; } ent_t;
    typedef struct { logic rdy; logic ldr; logic [31:0] ldd; logic we; logic [31:0] addr;
                     logic [31:0] wd; logic [31:0] pc; int cnt; } exp_t;

    ent_t        mq[$];
    exp_t        exq[$];
    logic [31:0] ref_mem [64];
    int          checks = 0;
    int          errors = 0;
    logic        m_rst, m_drain, m_coal, m_alloc;
    logic [31:0] m_wd, m_sa, m_sd, m_spc;
    logic [3:0]  m_sbe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and predict what the buffer must present
    task automatic drive(input logic rst, input logic ldr, input logic [31:0] lda,
                         input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sbe, input logic [31:0] spc, input logic push);
        exp_t e;
        int   n;
        reset = rst; bus.ld_req = ldr; bus.ld_addr = lda;
        bus.st_valid = sv; bus.st_addr = sa; bus.st_wdata = sd; bus.st_be = sbe; bus.st_pc = spc;
        m_rst = rst; m_sa = sa; m_sd = sd; m_sbe = sbe; m_spc = spc;
        n = mq.size();
        m_drain = !ldr && n > 0;
        m_coal  = sv && n > 0 && mq[n-1].wa == sa[31:2] && !(m_drain && n == 1);
        m_alloc = sv && sbe != 4'b0000 && !m_coal && n < DEPTH;
        e.rdy = (n < DEPTH) || m_coal;
        e.ldr = ldr;
        e.cnt = n;
        e.ldd = ref_mem[lda[7:2]];
        for (int b = 0; b < 4; b++) begin
            for (int k = n - 1; k >= 0; k--) begin
                if (mq[k].wa == lda[31:2] && mq[k].be[b]) begin
                    e.ldd[8*b +: 8] = mq[k].d[8*b +: 8];
                    break;
                end
            end
        end
        e.we = 1'b0; e.addr = 32'h0; e.wd = 32'h0; e.pc = 32'h0;
        if (ldr) begin
            e.addr = {lda[31:2], 2'b00};
        end else if (n > 0) begin
            e.we   = 1'b1;
            e.addr = {mq[0].wa, 2'b00};
            e.pc   = mq[0].pc;
            e.wd   = ref_mem[mq[0].wa[5:0]];
            for (int b = 0; b < 4; b++)
                if (mq[0].be[b]) e.wd[8*b +: 8] = mq[0].d[8*b +: 8];
        end
        m_wd = e.wd;
        if (push) exq.push_back(e);
    endtask

    // Advance the clock and commit the predicted state change to the model
    task automatic tick();
        ent_t t;
        @(posedge clk);
        if (m_rst) begin
            mq.delete();
        end else begin
            if (m_drain) begin
                ref_mem[mq[0].wa[5:0]] = m_wd;
                void'(mq.pop_front());
            end
            if (m_coal) begin
                t = mq[mq.size()-1];
                for (int b = 0; b < 4; b++) if (m_sbe[b]) t.d[8*b +: 8] = m_sd[8*b +: 8];
                t.be = t.be | m_sbe;
                t.pc = m_spc;
                mq[mq.size()-1] = t;
            end
            if (m_alloc) begin
                t.wa = m_sa[31:2]; t.d = m_sd; t.be = m_sbe; t.pc = m_spc;
                mq.push_back(t);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ldr, input logic [31:0] lda);
        drive(1'b0, ldr, lda, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    endtask

    task automatic st(input logic ldr, input logic [31:0] lda, input logic [31:0] sa,
                      input logic [31:0] sd, input logic [3:0] sbe, input logic [31:0] spc);
        drive(1'b0, ldr, lda, 1'b1, sa, sd, sbe, spc, 1'b1);
    endtask

    initial begin
        exp_t        me;
        logic [3:0]  be;
        logic        r;
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
        fork
            forever begin
                @(negedge clk);
                if (exq.size() > 0) begin
                    me = exq.pop_front();
                    chk("st_ready", 32'(bus.st_ready), 32'(me.rdy));
                    chk("count", 32'(bus.count), 32'(me.cnt));
                    chk("empty", 32'(bus.empty), 32'(me.cnt == 0));
                    chk("dm_we", 32'(bus.dm_we), 32'(me.we));
                    chk("dm_addr", bus.dm_addr, me.addr);
                    if (me.ldr) begin
                        chk("ld_data", bus.ld_data, me.ldd);
                    end else begin
                        chk("dm_wd", bus.dm_wd, me.wd);
                        chk("dm_pc", bus.dm_pc, me.pc);
                    end
                end
            end
        join_none

        mem_init = 1'b1;
        drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h10, 32'h5555_5555, 4'b1111, 32'h0, 1'b1); tick();
        mem_init = 1'b0;

        // Single sw drains the next cycle
        st(1'b0, 32'h0, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h100); tick();
        idle(1'b0, 32'h0); #2;
        chk("sw_we", 32'(bus.dm_we), 32'd1);
        chk("sw_addr", bus.dm_addr, 32'h10);
        chk("sw_wd", bus.dm_wd, 32'hDEAD_BEEF);
        chk("sw_pc", bus.dm_pc, 32'h100);
        tick();
        idle(1'b0, 32'h0); #2; chk("sw_empty", 32'(bus.empty), 32'd1); tick();

        // Byte store read-modify-write
        st(1'b0, 32'h0, 32'h20, 32'h1122_3344, 4'b1111, 32'h104); tick();
        idle(1'b0, 32'h0); tick();
        st(1'b0, 32'h0, 32'h21, 32'h0000_AA00, 4'b0010, 32'h108); tick();
        idle(1'b0, 32'h0); #2; chk("sb_rmw", bus.dm_wd, 32'h1122_AA44); tick();

        // Coalesce and forward while loads hold the port
        st(1'b0, 32'h0, 32'h30, 32'h0, 4'b1111, 32'h10C); tick();
        idle(1'b0, 32'h0); tick();
        st(1'b1, 32'h30, 32'h30, 32'hBEEF_0000, 4'b1100, 32'h110); tick();
        st(1'b1, 32'h30, 32'h30, 32'h0000_0077, 4'b0001, 32'h114); #2;
        chk("coal_ready", 32'(bus.st_ready), 32'd1); tick();
        idle(1'b1, 32'h30); #2;
        chk("coal_count", 32'(bus.count), 32'd1);
        chk("fwd_data", bus.ld_data, 32'hBEEF_0077);
        tick();

        // Fill to DEPTH, then backpressure and coalesce-when-full
        st(1'b1, 32'h0, 32'h40, 32'h4444_4444, 4'b1111, 32'h118); tick();
        st(1'b1, 32'h0, 32'h50, 32'h5555_5555, 4'b1111, 32'h11C); tick();
        st(1'b1, 32'h0, 32'h60, 32'h6666_6666, 4'b1111, 32'h120); tick();
        st(1'b1, 32'h0, 32'h70, 32'h7777_7777, 4'b1111, 32'h124); #2;
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.st_ready), 32'd0);
        tick();
        st(1'b1, 32'h0, 32'h60, 32'h1234_5678, 4'b1111, 32'h128); #2;
        chk("full_coal_ready", 32'(bus.st_ready), 32'd1); tick();
        idle(1'b1, 32'h0); #2; chk("full_coal_count", 32'(bus.count), 32'd4); tick();
        for (int k = 0; k < 4; k++) begin
            idle(1'b0, 32'h0); #2;
            chk("fifo_order", bus.dm_addr, 32'h30 + 32'(k) * 32'h10);
            tick();
        end
        idle(1'b0, 32'h0); #2; chk("drained_empty", 32'(bus.empty), 32'd1); tick();

        // Simultaneous allocate and drain
        st(1'b1, 32'h0, 32'h80, 32'h8080_8080, 4'b1111, 32'h130); tick();
        st(1'b1, 32'h0, 32'h84, 32'h8484_8484, 4'b1111, 32'h134); tick();
        st(1'b0, 32'h0, 32'h88, 32'h8888_8888, 4'b1111, 32'h138); #2;
        chk("simul_oldest", bus.dm_addr, 32'h80); tick();
        idle(1'b1, 32'h0); #2; chk("simul_count", 32'(bus.count), 32'd2); tick();
        repeat (3) begin idle(1'b0, 32'h0); tick(); end

        // Reset with three entries pending and a store offered in the reset cycle
        st(1'b1, 32'h0, 32'h90, 32'h9090_9090, 4'b1111, 32'h140); tick();
        st(1'b1, 32'h0, 32'h94, 32'h9494_9494, 4'b1111, 32'h144); tick();
        st(1'b1, 32'h0, 32'h98, 32'h9898_9898, 4'b1111, 32'h148); tick();
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h9C, 32'h9C9C_9C9C, 4'b1111, 32'h14C, 1'b1); tick();
        idle(1'b0, 32'h0); #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_we", 32'(bus.dm_we), 32'd0);
        chk("rst_ready", 32'(bus.st_ready), 32'd1);
        tick();
        repeat (2) begin idle(1'b0, 32'h0); tick(); end

        // Random traffic over a few hot words
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 7))
                0: be = 4'b1111;
                1: be = 4'b0011;
                2: be = 4'b1100;
                3: be = 4'b0001;
                4: be = 4'b0010;
                5: be = 4'b0100;
                6: be = 4'b1000;
                default: be = 4'b0000;
            endcase
            drive(r, r ? 1'b1 : ($urandom_range(0, 9) < 4),
                  (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 6),
                  (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3)),
                  $urandom, be, $urandom, 1'b1);
            tick();
        end
        repeat (DEPTH + 2) begin idle(1'b0, 32'h0); tick(); end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exq.size()), 32'd0);
        for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
